// File: rtl/ram_test_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : ram_test_sequencer
//  Purpose  : Runs a four-pattern march test (write pass, then read/compare
//             pass per pattern) on the RAM test datapath, accumulating the
//             read-pass error counts and guarding every pass with timeouts.
//  Revision : 1.0 - initial release
// ============================================================================
module ram_test_sequencer #(
  parameter int START_TO = 8,
  parameter int PASS_TO  = 20000
) (
  input  logic        sys_clk,
  input  logic        all_clear,
  input  logic        test_go,
  input  logic        test_abort,
  input  logic        pass_busy,
  input  logic [15:0] err_count,
  output logic        set_start,
  output logic        wr_rd_OE_buff,
  output logic [7:0]  pattern,
  output logic        err_clr,
  output logic        test_busy,
  output logic        test_done,
  output logic        test_pass,
  output logic [17:0] total_err,
  output logic [1:0]  fail_idx,
  output logic        timeout_flag
);

  localparam logic [14:0] START_LIM = 15'(START_TO);
  localparam logic [14:0] PASS_LIM  = 15'(PASS_TO);

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_CLR        = 4'd1,
    S_SETUP_WR   = 4'd2,
    S_GO_WR      = 4'd3,
    S_WAIT_WR_HI = 4'd4,
    S_WAIT_WR_LO = 4'd5,
    S_SETUP_RD   = 4'd6,
    S_GO_RD      = 4'd7,
    S_WAIT_RD_HI = 4'd8,
    S_WAIT_RD_LO = 4'd9,
    S_ACCUM      = 4'd10,
    S_DRAIN      = 4'd11,
    S_DONE       = 4'd12
  } state_t;

  state_t      state_q;
  logic [1:0]  idx_q;
  logic [14:0] cnt_q;
  logic        fail_seen_q;
  logic        set_start_q, wr_mode_q, err_clr_q, busy_q, done_q, pass_q, tflag_q;
  logic [7:0]  pattern_q;
  logic [17:0] total_q;
  logic [1:0]  fail_idx_q;

  logic        abort_req;
  logic        hi_timeout;
  logic        lo_timeout;
  logic [17:0] total_d;

  // Fixed data pattern table.
  function automatic logic [7:0] pat_of(input logic [1:0] i);
    case (i)
      2'd0:    pat_of = 8'h55;
      2'd1:    pat_of = 8'hAA;
      2'd2:    pat_of = 8'h00;
      default: pat_of = 8'hFF;
    endcase
  endfunction

  // Abort/timeout qualifiers and the running error sum for the ACCUM step.
  always_comb begin
    abort_req  = test_abort && (state_q != S_IDLE) && (state_q != S_DONE) &&
                 (state_q != S_DRAIN);
    hi_timeout = ((state_q == S_WAIT_WR_HI) || (state_q == S_WAIT_RD_HI)) &&
                 !pass_busy && (cnt_q == START_LIM);
    lo_timeout = ((state_q == S_WAIT_WR_LO) || (state_q == S_WAIT_RD_LO)) &&
                 pass_busy && (cnt_q == PASS_LIM);
    total_d    = total_q + {2'b00, err_count};
  end

  // Sequencer FSM; every output is set on entry to the state that owns it.
  always_ff @(posedge sys_clk) begin
    if (all_clear) begin
      state_q     <= S_IDLE;
      idx_q       <= 2'd0;
      cnt_q       <= 15'd0;
      fail_seen_q <= 1'b0;
      set_start_q <= 1'b0;
      wr_mode_q   <= 1'b0;
      err_clr_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      tflag_q     <= 1'b0;
      pattern_q   <= 8'h00;
      total_q     <= 18'd0;
      fail_idx_q  <= 2'd0;
    end else begin
      set_start_q <= 1'b0;
      err_clr_q   <= 1'b0;
      done_q      <= 1'b0;
      cnt_q       <= cnt_q + 15'd1;
      if (abort_req) begin
        // Abort wins over everything, but a coincident timeout is still recorded.
        state_q <= S_DRAIN;
        if (hi_timeout || lo_timeout) tflag_q <= 1'b1;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (test_go && !test_abort) begin
              total_q     <= 18'd0;
              fail_idx_q  <= 2'd0;
              fail_seen_q <= 1'b0;
              pass_q      <= 1'b0;
              tflag_q     <= 1'b0;
              idx_q       <= 2'd0;
              busy_q      <= 1'b1;
              err_clr_q   <= 1'b1;
              state_q     <= S_CLR;
            end
          end
          S_CLR: begin
            wr_mode_q <= 1'b1;
            pattern_q <= pat_of(idx_q);
            state_q   <= S_SETUP_WR;
          end
          S_SETUP_WR: begin
            set_start_q <= 1'b1;
            state_q     <= S_GO_WR;
          end
          S_GO_WR: begin
            cnt_q   <= 15'd0;
            state_q <= S_WAIT_WR_HI;
          end
          S_WAIT_WR_HI, S_WAIT_RD_HI: begin
            if (pass_busy) begin
              cnt_q   <= 15'd0;
              state_q <= (state_q == S_WAIT_WR_HI) ? S_WAIT_WR_LO : S_WAIT_RD_LO;
            end else if (hi_timeout) begin
              tflag_q <= 1'b1;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
          S_WAIT_WR_LO: begin
            if (!pass_busy) begin
              wr_mode_q <= 1'b0;
              state_q   <= S_SETUP_RD;
            end else if (lo_timeout) begin
              tflag_q <= 1'b1;
              state_q <= S_DRAIN;
            end
          end
          S_SETUP_RD: begin
            set_start_q <= 1'b1;
            state_q     <= S_GO_RD;
          end
          S_GO_RD: begin
            cnt_q   <= 15'd0;
            state_q <= S_WAIT_RD_HI;
          end
          S_WAIT_RD_LO: begin
            if (!pass_busy) begin
              state_q <= S_ACCUM;
            end else if (lo_timeout) begin
              tflag_q <= 1'b1;
              state_q <= S_DRAIN;
            end
          end
          S_ACCUM: begin
            total_q <= total_d;
            if ((err_count != 16'd0) && !fail_seen_q) begin
              fail_idx_q  <= idx_q;
              fail_seen_q <= 1'b1;
            end
            if (idx_q == 2'd3) begin
              pass_q  <= (total_d == 18'd0) && !tflag_q;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              idx_q     <= idx_q + 2'd1;
              err_clr_q <= 1'b1;
              state_q   <= S_CLR;
            end
          end
          S_DRAIN: begin
            // Reached only via abort or timeout, so the result is always a fail.
            if (!pass_busy) begin
              pass_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
          S_DONE: begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign set_start     = set_start_q;
  assign wr_rd_OE_buff = wr_mode_q;
  assign pattern       = pattern_q;
  assign err_clr       = err_clr_q;
  assign test_busy     = busy_q;
  assign test_done     = done_q;
  assign test_pass     = pass_q;
  assign total_err     = total_q;
  assign fail_idx      = fail_idx_q;
  assign timeout_flag  = tflag_q;

endmodule
`default_nettype wire

// File: doc/ram_test_sequencer.md
# ram_test_sequencer

Sequencer that runs a complete multi-pattern march test on the RAM test datapath. For each of four fixed data patterns it commands a full write pass, then a full read/compare pass, and accumulates the datapath's per-pass error count. It sits between the SPI/command layer (`test_go`/status) and the RAM datapath (`set_start`, `wr_rd_OE_buff`, `ready_to_SPI`, `err_count`), replacing manual pass-by-pass control.

## Interface
- `START_TO`, default 8: max cycles from `set_start` pulse to `pass_busy` rising.
- `PASS_TO`, default 20000: max cycles `pass_busy` may stay high (16384 addresses plus margin).
- `sys_clk` in 1: single clock; all logic is rising-edge.
- `all_clear` in 1: synchronous, active-high reset.
- `test_go` in 1: start full test; sampled only in IDLE.
- `test_abort` in 1: abort the running test; level, sampled every cycle.
- `pass_busy` in 1: datapath pass running; connects to `ready_to_SPI`.
- `err_count` in 16: datapath error count for the current pass.
- `set_start` out 1: one-cycle pass-start pulse to the datapath.
- `wr_rd_OE_buff` out 1: pass mode, 1 = write, 0 = read/compare.
- `pattern` out 8: data pattern for the current pass.
- `err_clr` out 1: one-cycle pulse; ORed into the datapath error-counter clear.
- `test_busy` out 1: high from test acceptance until DONE exits.
- `test_done` out 1: one-cycle completion pulse.
- `test_pass` out 1: held result; 1 = zero errors, no timeout, no abort.
- `total_err` out 18: sum of the four read-pass `err_count` values. Cannot overflow (4×65535 < 2^18).
- `fail_idx` out 2: index of the first pattern with a nonzero error count.
- `timeout_flag` out 1: held; set when a `START_TO` or `PASS_TO` limit expires.

## Operation
- Pattern table, indexed by `idx` 0..3: 0x55, 0xAA, 0x00, 0xFF.
- States: IDLE, CLR, SETUP_WR, GO_WR, WAIT_WR_HI, WAIT_WR_LO, SETUP_RD, GO_RD, WAIT_RD_HI, WAIT_RD_LO, ACCUM, DRAIN, DONE.
- **IDLE**, on `test_go`=1:
  - clears `total_err`, `fail_idx`, `test_pass`, `timeout_flag`; sets `idx`=0;
  - moves to CLR.
- **CLR**: `err_clr`=1 for one cycle, then SETUP_WR.
- **SETUP_WR**: drives `wr_rd_OE_buff`=1 and `pattern`=table[idx].
- **GO_WR**: `set_start`=1 for one cycle.
- **WAIT_WR_HI**: waits for `pass_busy`=1.
- **WAIT_WR_LO**: waits for `pass_busy`=0, then SETUP_RD.
- **Read half**: SETUP_RD drives `wr_rd_OE_buff`=0; GO_RD, WAIT_RD_HI and WAIT_RD_LO behave as the write half.
- **ACCUM**:
  - `total_err` += `err_count`;
  - if `err_count`≠0 and no failure recorded yet, `fail_idx`=idx;
  - if idx=3, go to DONE; otherwise idx+1 and CLR.
- Write-pass `err_count` is never accumulated.
- **DONE**: `test_done`=1 for one cycle. `test_pass`=1 only if `total_err`=0, `timeout_flag`=0 and no abort. Then IDLE.
- **Mode/pattern stability**: `wr_rd_OE_buff` and `pattern` change only in SETUP states. They are stable at least one cycle before `set_start` and throughout the pass.
- **Timeouts**:
  - a 15-bit counter resets on entry to each WAIT state;
  - in WAIT_*_HI, reaching `START_TO` sets `timeout_flag` and goes to DONE;
  - in WAIT_*_LO, reaching `PASS_TO` sets `timeout_flag` and goes to DRAIN;
  - DRAIN waits for `pass_busy`=0 (no limit), then DONE.
- **Abort**:
  - `test_abort`=1 in any state other than IDLE, DONE or DRAIN goes to DRAIN;
  - `set_start` is never issued after the abort;
  - DONE then reports `test_pass`=0 and keeps the partial `total_err`.
- **Simultaneous events**:
  - `test_go` with `test_abort` in IDLE: abort wins, stay IDLE;
  - `test_go` while busy: ignored;
  - abort in the same cycle as a timeout: abort path taken, `timeout_flag` still set.

## Timing
- Reset values: all outputs 0, `pattern`=0x00, state IDLE, `idx`=0.
- `all_clear` mid-test returns to IDLE next edge with no `test_done` pulse.
- `test_go` at edge N:
  - `err_clr` high in cycle N+1;
  - `wr_rd_OE_buff`=1 from N+2;
  - `set_start` high in cycle N+3.
- `err_count` is sampled in ACCUM, one cycle after `pass_busy` is seen low.
- Write→read turnaround: `pass_busy` seen low at edge M, `wr_rd_OE_buff`=0 from M+1, `set_start` at M+2.
- Inter-pattern gap after a read pass falls: ACCUM, CLR, SETUP, GO, so `set_start` occurs 4 cycles after `pass_busy` is seen low.
- `test_done` is asserted one cycle after the final ACCUM. `test_busy` falls on the edge after `test_done`.
- All flags (`test_pass`, `timeout_flag`, `fail_idx`, `total_err`) hold until the next accepted `test_go`.

## Test plan
- **Clean run**: model with `pass_busy` high for 16384 cycles after a 2-cycle delay and `err_count`=0. Expect 8 `set_start` pulses, mode sequence 1,0 ×4, patterns 55,55,AA,AA,00,00,FF,FF, `test_pass`=1, `total_err`=0.
- **Errors**: `err_count`=3 on read pass idx1, 5 on idx3, 7 on every write pass. Expect `total_err`=8, `fail_idx`=1, `test_pass`=0.
- **Start timeout**: model never raises `pass_busy`. Expect `timeout_flag`=1 and `test_done` 1+`START_TO`+1 cycles after GO_WR, with only 1 `set_start`.
- **Abort**: `test_abort` asserted mid read pass of idx2. Expect no further `set_start`, `test_done` only after `pass_busy` falls, `test_pass`=0.
- **Pass timeout**: `pass_busy` stuck high. Expect DRAIN until it is released, then `timeout_flag`=1 and `test_done`.
- **Reset and `test_go` edge cases**: `all_clear` during WAIT_RD_LO returns all outputs to reset values with no `test_done`. `test_go` while busy is ignored, and `test_go`+`test_abort` together in IDLE stays IDLE.
